// File: rtl/router_fifo.sv
// router_fifo: 16x9 packet FIFO for one router output port, tracking packet length on read.
// Define ROUTER_FIFO_TRISTATE_EN to park data_out at high impedance when idle.
module router_fifo (
  input  logic       clk,
  input  logic       resetn,
  input  logic       soft_reset,
  input  logic       write_enb,
  input  logic       read_enb,
  input  logic       lfd_state,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       full,
  output logic       empty
);

  logic [8:0] mem_q [16];
  logic [4:0] wr_ptr_q;
  logic [4:0] rd_ptr_q;
  logic [6:0] cnt_q;
  logic [6:0] cnt_d;
  logic [7:0] data_out_q;
  logic       idle_q;
  logic       wr_acc;
  logic       rd_acc;
  logic [8:0] rd_entry;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[3:0] == rd_ptr_q[3:0]) && (wr_ptr_q[4] != rd_ptr_q[4]);
  assign wr_acc   = write_enb && !full;
  assign rd_acc   = read_enb && !empty;
  assign rd_entry = mem_q[rd_ptr_q[3:0]];

  // Idle is a separate flag so the parked value can be driven as Z on a shared bus.
`ifdef ROUTER_FIFO_TRISTATE_EN
  assign data_out = idle_q ? 8'hzz : data_out_q;
`else
  assign data_out = idle_q ? 8'h00 : data_out_q;
`endif

  // Header loads payload length plus one for the trailing parity byte.
  always_comb begin
    cnt_d = cnt_q;
    if (rd_acc) begin
      if (rd_entry[8]) begin
        cnt_d = {1'b0, rd_entry[7:2]} + 7'd1;
      end else if (cnt_q != 7'd0) begin
        cnt_d = cnt_q - 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      data_out_q <= 8'h00;
      idle_q     <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= '0;
      end
    end else if (soft_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      data_out_q <= 8'h00;
      idle_q     <= 1'b1;
    end else begin
      if (wr_acc) begin
        mem_q[wr_ptr_q[3:0]] <= {lfd_state, data_in};
        wr_ptr_q             <= wr_ptr_q + 5'd1;
      end
      if (rd_acc) begin
        data_out_q <= rd_entry[7:0];
        idle_q     <= 1'b0;
        rd_ptr_q   <= rd_ptr_q + 5'd1;
      end else if (cnt_q == 7'd0) begin
        data_out_q <= 8'h00;
        idle_q     <= 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: vector table, directed corner sequences and random traffic against a queue model.
module tb_router_fifo;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  router_fifo dut (
    .clk       (clk),
    .resetn    (resetn),
    .soft_reset(soft_reset),
    .write_enb (write_enb),
    .read_enb  (read_enb),
    .lfd_state (lfd_state),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

`ifdef ROUTER_FIFO_TRISTATE_EN
  localparam logic [7:0] IDLE = 8'hzz;
`else
  localparam logic [7:0] IDLE = 8'h00;
`endif

  typedef struct {
    logic       rn;
    logic       sr;
    logic       we;
    logic       re;
    logic       lfd;
    logic [7:0] din;
    logic [7:0] edout;
    logic       efull;
    logic       eempty;
  } vec_t;

  vec_t       tbl[$];
  int         n_pass = 0;
  int         n_total = 0;
  logic [8:0] mq[$];
  int         mcnt = 0;
  logic [7:0] mdout = 8'h00;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  // Applies one cycle of inputs, advances the queue model and compares the DUT to it.
  task automatic step(input logic rn, input logic sr, input logic we, input logic re,
                      input logic lfd, input logic [7:0] d);
    logic       mfull;
    logic       mempty;
    logic [8:0] e;
    @(negedge clk);
    resetn = rn; soft_reset = sr; write_enb = we; read_enb = re; lfd_state = lfd; data_in = d;
    @(posedge clk);
    #1;
    mfull  = (mq.size() == 16);
    mempty = (mq.size() == 0);
    if (!rn) begin
      mq.delete(); mcnt = 0; mdout = 8'h00;
    end else if (sr) begin
      mq.delete(); mcnt = 0; mdout = IDLE;
    end else begin
      if (re && !mempty) begin
        e = mq.pop_front();
        mdout = e[7:0];
        if (e[8]) mcnt = int'(e[7:2]) + 1;
        else if (mcnt > 0) mcnt--;
      end else if (mcnt == 0) begin
        mdout = IDLE;
      end
      if (we && !mfull) mq.push_back({lfd, d});
    end
    chk("model_dout", data_out, mdout);
    chk("model_full", {7'd0, full}, {7'd0, (mq.size() == 16)});
    chk("model_empty", {7'd0, empty}, {7'd0, (mq.size() == 0)});
  endtask

  task automatic add(input logic rn, input logic sr, input logic we, input logic re,
                     input logic lfd, input logic [7:0] d, input logic [7:0] edout,
                     input logic efull, input logic eempty);
    vec_t v;
    v.rn = rn; v.sr = sr; v.we = we; v.re = re; v.lfd = lfd; v.din = d;
    v.edout = edout; v.efull = efull; v.eempty = eempty;
    tbl.push_back(v);
  endtask

  initial begin
    // header 0C (3 payload bytes), payload, parity, then drain
    add(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
    add(1, 0, 1, 0, 1, 8'h0C, IDLE,  0, 0);
    add(1, 0, 1, 0, 0, 8'hA1, IDLE,  0, 0);
    add(1, 0, 1, 0, 0, 8'hA2, IDLE,  0, 0);
    add(1, 0, 1, 0, 0, 8'hA3, IDLE,  0, 0);
    add(1, 0, 1, 0, 0, 8'h5F, IDLE,  0, 0);
    add(1, 0, 0, 1, 0, 8'h00, 8'h0C, 0, 0);
    add(1, 0, 0, 1, 0, 8'h00, 8'hA1, 0, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'hA1, 0, 0);
    add(1, 0, 0, 1, 0, 8'h00, 8'hA2, 0, 0);
    add(1, 0, 0, 1, 0, 8'h00, 8'hA3, 0, 0);
    add(1, 0, 0, 1, 0, 8'h00, 8'h5F, 0, 1);
    add(1, 0, 0, 0, 0, 8'h00, IDLE,  0, 1);
    add(1, 0, 0, 1, 0, 8'h00, IDLE,  0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rn, tbl[i].sr, tbl[i].we, tbl[i].re, tbl[i].lfd, tbl[i].din);
      chk($sformatf("vec%0d_dout", i), data_out, tbl[i].edout);
      chk($sformatf("vec%0d_full", i), {7'd0, full}, {7'd0, tbl[i].efull});
      chk($sformatf("vec%0d_empty", i), {7'd0, empty}, {7'd0, tbl[i].eempty});
    end

    // fill to 16, drop the 17th, drain in order
    step(0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) step(1, 0, 1, 0, 0, 8'(8'h40 + i));
    chk("fill_full", {7'd0, full}, 8'd1);
    step(1, 0, 1, 0, 0, 8'hEE);
    chk("drop17_full", {7'd0, full}, 8'd1);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 1, 0, 8'h00);
      chk($sformatf("drain%0d", i), data_out, 8'(8'h40 + i));
    end
    chk("drain_empty", {7'd0, empty}, 8'd1);

    // simultaneous read and write while full: read wins, write dropped
    for (int i = 0; i < 16; i++) step(1, 0, 1, 0, 0, 8'(8'h60 + i));
    step(1, 0, 1, 1, 0, 8'h77);
    chk("rw_full_dout", data_out, 8'h60);
    chk("rw_full_full", {7'd0, full}, 8'd0);
    for (int i = 0; i < 15; i++) step(1, 0, 0, 1, 0, 8'h00);
    chk("rw_full_last", data_out, 8'h6F);
    chk("rw_full_empty", {7'd0, empty}, 8'd1);

    // soft reset mid-packet
    step(0, 0, 0, 0, 0, 8'h00);
    step(1, 0, 1, 0, 1, 8'h10);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, 8'(8'hB0 + i));
    step(1, 0, 0, 1, 0, 8'h00);
    chk("sr_hdr", data_out, 8'h10);
    step(1, 1, 0, 0, 0, 8'h00);
    chk("sr_empty", {7'd0, empty}, 8'd1);
    chk("sr_full", {7'd0, full}, 8'd0);
    chk("sr_dout", data_out, IDLE);
    step(1, 0, 1, 0, 0, 8'h3C);
    step(1, 0, 0, 1, 0, 8'h00);
    chk("sr_3c", data_out, 8'h3C);

    // pointer wrap
    step(0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 1, 0, 0, 8'(i + 1));
      chk($sformatf("wrap_full_w%0d", i), {7'd0, full}, 8'd0);
      step(1, 0, 0, 1, 0, 8'h00);
      chk($sformatf("wrap_data%0d", i), data_out, 8'(i + 1));
    end

    // random traffic with alternating write-heavy / read-heavy phases
    for (int i = 0; i < 3000; i++) begin
      logic wheavy;
      wheavy = ((i / 150) % 2) == 0;
      step($urandom_range(99) != 0,
           $urandom_range(63) == 0,
           $urandom_range(9) < (wheavy ? 7 : 3),
           $urandom_range(9) < (wheavy ? 3 : 7),
           $urandom_range(5) == 0,
           8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port resetn, input, 1; reset is resetn, synchronous, active-low; clock is clk.
REQ-003 SHALL have port soft_reset, input, 1, synchronous flush request from the sync stage's per-port timeout.
REQ-004 SHALL have port write_enb, input, 1, this FIFO's one-hot write strobe from the sync stage.
REQ-005 SHALL have port read_enb, input, 1, read strobe from the output-port consumer.
REQ-006 SHALL have port lfd_state, input, 1, high when data_in carries a packet header byte.
REQ-007 SHALL have port data_in, input, 8, packet byte: header is [7:2] payload length, [1:0] address.
REQ-008 SHALL have port data_out, output, 8, registered read data.
REQ-009 SHALL have port full, output, 1, combinational, storage holds 16 entries.
REQ-010 SHALL have port empty, output, 1, combinational, storage holds 0 entries.

Function
REQ-011 SHALL store 16 entries of 9 bits; bit 8 = lfd_state captured with the byte, bits 7:0 = data_in.
REQ-012 SHALL use 5-bit write and read pointers; low 4 bits index storage, bit 4 is the wrap bit.
REQ-013 SHALL assert empty when pointers are equal; full when low 4 bits equal and wrap bits differ.
REQ-014 SHALL accept a write on a clk edge iff write_enb=1 and full=0; then store {lfd_state,data_in} and increment write pointer (mod 32).
REQ-015 SHALL accept a read on a clk edge iff read_enb=1 and empty=0; then load data_out with entry[7:0] and increment read pointer; data_out valid the cycle after the strobe (1-cycle latency).
REQ-016 SHALL drop writes while full and ignore reads while empty, with no pointer change.
REQ-017 SHALL perform both a read and a write in one cycle when both are accepted; full/empty evaluated from pre-edge pointers.
REQ-018 SHALL keep a 7-bit packet counter: on accepted read of an entry with bit 8=1, load counter with entry[7:2]+1 (payload plus parity).
REQ-019 SHALL decrement the counter on each accepted read of an entry with bit 8=0 while counter is nonzero; counter never underflows.
REQ-020 SHALL drive data_out to the idle value on any edge with counter=0 and no accepted read; otherwise hold data_out when no read is accepted.
REQ-021 SHALL give soft_reset priority over read/write: pointers to 0, counter to 0, data_out to idle value; storage contents unchanged.

Reset
REQ-022 SHALL on resetn=0 at a clk edge clear both pointers, the counter and all 16 storage entries, and set data_out to 8'h00.
REQ-023 SHALL give resetn priority over soft_reset, write and read; after reset empty=1, full=0.

Configuration
REQ-024 SHALL honour macro ROUTER_FIFO_TRISTATE_EN: defined -> idle value of data_out is 8'hZZ (high impedance, shared output bus); undefined -> idle value is 8'h00.
REQ-025 SHALL keep all other behaviour, including data_out=8'h00 during resetn, identical under both settings.

Verification
REQ-026 SHALL check: reset, then write header 8'h0C with lfd_state=1, 3 payload bytes 8'hA1,A2,A3, parity 8'h5F -> empty=0 next cycle, five reads return 0C,A1,A2,A3,5F, empty=1 after the fifth.
REQ-027 SHALL check: 16 writes without reads -> full=1 after 16th; 17th write (8'hEE) dropped; 16 reads return first 16 bytes in order, never 8'hEE.
REQ-028 SHALL check: full FIFO, read_enb=1 and write_enb=1 same cycle -> read accepted, write dropped, full=0 afterwards.
REQ-029 SHALL check: after final parity read, next idle cycle data_out=8'hZZ with ROUTER_FIFO_TRISTATE_EN defined and 8'h00 without.
REQ-030 SHALL check: 5 bytes stored, soft_reset=1 one cycle -> empty=1, full=0, data_out idle; subsequent write/read of 8'h3C returns 8'h3C.
REQ-031 SHALL check: pointer wrap -- 40 write/read pairs of incrementing bytes -> all bytes returned in order, full never asserted.
